mac_tx_arbiter: RTL and testbench

- Shares the single byte-wide MAC transmit interface between two packet sources.
  - Source 0 is the sample packetizer.
  - Source 1 is the control/response path.
- Grants whole packets, SOP through EOP, in round-robin order and inserts a fixed inter-packet gap.
- Polices each packet's framing and length, and aborts malformed packets with tx_err.
- Runs entirely in the MAC transmit-clock domain.

---
 rtl/mac_tx_arbiter_if.sv | 63 ++++++
 rtl/mac_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// mac_tx_arbiter_if
//
// Bundles the two packet-source ports and the byte-wide MAC transmit port
// shared by mac_tx_arbiter.
//
// Signals:
//   s0_*/s1_*  : req/gnt/rdy handshake and data/sop/eop/wren byte stream of
//                packet source 0 (sample packetizer) and source 1
//                (control/response path)
//   tx_*       : registered byte stream to the MAC plus its tx_rdy/tx_a_full
//                flow-control inputs
//   abort_cnt  : saturating count of aborted packets
//
// Modports:
//   master : the arbiter (drives grants, rdy, the MAC stream and abort_cnt)
//   slave  : the sources and the MAC as seen from outside the arbiter
// ----------------------------------------------------------------------------
interface mac_tx_arbiter_if;
    logic       s0_req;
    logic       s0_gnt;
    logic       s0_rdy;
    logic [7:0] s0_data;
    logic       s0_sop;
    logic       s0_eop;
    logic       s0_wren;

    logic       s1_req;
    logic       s1_gnt;
    logic       s1_rdy;
    logic [7:0] s1_data;
    logic       s1_sop;
    logic       s1_eop;
    logic       s1_wren;

    logic [7:0] tx_data;
    logic       tx_sop;
    logic       tx_eop;
    logic       tx_err;
    logic       tx_wren;
    logic       tx_rdy;
    logic       tx_a_full;

    logic [7:0] abort_cnt;

    modport master (
        input  s0_req, s0_data, s0_sop, s0_eop, s0_wren,
        input  s1_req, s1_data, s1_sop, s1_eop, s1_wren,
        input  tx_rdy, tx_a_full,
        output s0_gnt, s0_rdy, s1_gnt, s1_rdy,
        output tx_data, tx_sop, tx_eop, tx_err, tx_wren,
        output abort_cnt
    );

    modport slave (
        output s0_req, s0_data, s0_sop, s0_eop, s0_wren,
        output s1_req, s1_data, s1_sop, s1_eop, s1_wren,
        output tx_rdy, tx_a_full,
        input  s0_gnt, s0_rdy, s1_gnt, s1_rdy,
        input  tx_data, tx_sop, tx_eop, tx_err, tx_wren,
        input  abort_cnt
    );
endinterface

// File: rtl/mac_tx_arbiter.sv
// ----------------------------------------------------------------------------
// mac_tx_arbiter
//
// Shares one byte-wide MAC transmit interface between two packet sources.
// Whole packets (SOP..EOP) are granted round-robin, a fixed idle gap is
// inserted after each packet, and malformed or over-long packets are cut
// short with tx_eop + tx_err. Everything runs in the MAC transmit clock.
//
// Ports:
//   clk  : MAC transmit clock
//   rst  : asynchronous active-high reset
//   bus  : mac_tx_arbiter_if.master (source handshakes, MAC stream, abort_cnt)
//
// Parameters:
//   MAX_PKT_BYTES : longest legal packet; the byte that reaches this length
//                   without eop is sent with tx_eop/tx_err and the grant drops
//   GAP_CYCLES    : idle cycles between a packet end and the next grant (>= 1)
// ----------------------------------------------------------------------------
module mac_tx_arbiter #(
    parameter int MAX_PKT_BYTES = 1514,
    parameter int GAP_CYCLES    = 4
) (
    input logic              clk,
    input logic              rst,
    mac_tx_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t           state_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             owner_q;     // source currently holding the grant
    logic             rrPtr_q;     // source favoured when both request
    logic [GAP_W-1:0] gapCnt_q;
    logic [CNT_W-1:0] byteCnt_q;
    logic [CNT_W-1:0] byteCnt_d;
    logic [7:0]       abortCnt_q;
    logic [7:0]       abortCnt_d;
    logic [7:0]       txData_q;
    logic             txSop_q;
    logic             txEop_q;
    logic             txErr_q;
    logic             txWren_q;

    logic             macOpen;
    logic             rdy0;
    logic             rdy1;
    logic [7:0]       selData;
    logic             selSop;
    logic             selEop;
    logic             fwd;
    logic             outSop;
    logic             outEop;
    logic             outErr;

    // rdy follows tx_a_full combinationally so a full MAC FIFO stalls the
    // source in the same cycle; only the one registered byte is in flight.
    assign macOpen = bus.tx_rdy & ~bus.tx_a_full;
    assign rdy0    = gnt0_q & macOpen;
    assign rdy1    = gnt1_q & macOpen;

    assign selData = owner_q ? bus.s1_data : bus.s0_data;
    assign selSop  = owner_q ? bus.s1_sop  : bus.s0_sop;
    assign selEop  = owner_q ? bus.s1_eop  : bus.s0_eop;
    assign fwd     = owner_q ? (bus.s1_wren & rdy1) : (bus.s0_wren & rdy0);

    assign byteCnt_d  = byteCnt_q + 1'b1;
    assign abortCnt_d = (abortCnt_q == 8'hFF) ? abortCnt_q : abortCnt_q + 8'd1;

    // Framing police for the byte being forwarded: a missing sop on the first
    // byte, a stray sop on a later byte, or reaching the length limit without
    // eop all close the packet early with tx_err.
    always_comb begin
        outSop = 1'b0;
        outEop = 1'b0;
        outErr = 1'b0;
        if (byteCnt_q == '0) begin
            outSop = 1'b1;
            if (!selSop) begin
                outEop = 1'b1;
                outErr = 1'b1;
            end else if (selEop) begin
                outEop = 1'b1;
            end else if (byteCnt_q == LAST_IDX) begin
                outEop = 1'b1;
                outErr = 1'b1;
            end
        end else if (selSop) begin
            outEop = 1'b1;
            outErr = 1'b1;
        end else if (selEop) begin
            outEop = 1'b1;
        end else if (byteCnt_q == LAST_IDX) begin
            outEop = 1'b1;
            outErr = 1'b1;
        end
    end

    // Arbitration FSM with registered grants and registered MAC stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            owner_q    <= 1'b0;
            rrPtr_q    <= 1'b0;
            gapCnt_q   <= '0;
            byteCnt_q  <= '0;
            abortCnt_q <= 8'd0;
            txData_q   <= 8'd0;
            txSop_q    <= 1'b0;
            txEop_q    <= 1'b0;
            txErr_q    <= 1'b0;
            txWren_q   <= 1'b0;
        end else begin
            txData_q <= 8'd0;
            txSop_q  <= 1'b0;
            txEop_q  <= 1'b0;
            txErr_q  <= 1'b0;
            txWren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    byteCnt_q <= '0;
                    if (bus.s0_req && (!bus.s1_req || !rrPtr_q)) begin
                        gnt0_q  <= 1'b1;
                        owner_q <= 1'b0;
                        state_q <= XFER;
                    end else if (bus.s1_req) begin
                        gnt1_q  <= 1'b1;
                        owner_q <= 1'b1;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (fwd) begin
                        txWren_q  <= 1'b1;
                        txData_q  <= selData;
                        txSop_q   <= outSop;
                        txEop_q   <= outEop;
                        txErr_q   <= outErr;
                        byteCnt_q <= byteCnt_d;
                        if (outErr) begin
                            abortCnt_q <= abortCnt_d;
                        end
                        // Normal or aborted end: release the MAC and hand
                        // priority to the other source.
                        if (outEop) begin
                            state_q  <= GAP;
                            gnt0_q   <= 1'b0;
                            gnt1_q   <= 1'b0;
                            rrPtr_q  <= ~owner_q;
                            gapCnt_q <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s0_gnt    = gnt0_q;
    assign bus.s1_gnt    = gnt1_q;
    assign bus.s0_rdy    = rdy0;
    assign bus.s1_rdy    = rdy1;
    assign bus.tx_data   = txData_q;
    assign bus.tx_sop    = txSop_q;
    assign bus.tx_eop    = txEop_q;
    assign bus.tx_err    = txErr_q;
    assign bus.tx_wren   = txWren_q;
    assign bus.abort_cnt = abortCnt_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mac_tx_arbiter
//
// Directed bench for mac_tx_arbiter (MAX_PKT_BYTES 1514, GAP_CYCLES 4).
// Inputs change 1 time unit after the rising clock edge; registered outputs
// are sampled 1 time unit after the edge that produced them.
// ----------------------------------------------------------------------------
module tb_mac_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;
    int   wrenPulses = 0;
    int   errPulses  = 0;

    mac_tx_arbiter_if bus();

    mac_tx_arbiter #(
        .MAX_PKT_BYTES(1514),
        .GAP_CYCLES   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count MAC write strobes and abort flags mid-cycle.
    always @(negedge clk) begin
        if (bus.tx_wren) wrenPulses++;
        if (bus.tx_err)  errPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] byteVal(input int src, input int i);
        return 8'((i * 7 + src * 100 + 3) & 255);
    endfunction

    function automatic logic gntOf(input int src);
        return (src == 0) ? bus.s0_gnt : bus.s1_gnt;
    endfunction

    task automatic idleInputs();
        bus.s0_data = 8'd0; bus.s0_sop = 1'b0; bus.s0_eop = 1'b0; bus.s0_wren = 1'b0;
        bus.s1_data = 8'd0; bus.s1_sop = 1'b0; bus.s1_eop = 1'b0; bus.s1_wren = 1'b0;
    endtask

    // Drive one byte on 'src' (the other source optionally writes junk),
    // sample both rdy lines before the edge, then step to 1 unit past it.
    task automatic applyStimulus(input int src, input logic [7:0] d, input logic sop,
                                 input logic eop, input logic wren, input logic otherWren,
                                 output logic rdyOwn, output logic rdyOther);
        if (src == 0) begin
            bus.s0_data = d;     bus.s0_sop = sop;       bus.s0_eop = eop;       bus.s0_wren = wren;
            bus.s1_data = 8'hEE; bus.s1_sop = otherWren; bus.s1_eop = otherWren; bus.s1_wren = otherWren;
        end else begin
            bus.s1_data = d;     bus.s1_sop = sop;       bus.s1_eop = eop;       bus.s1_wren = wren;
            bus.s0_data = 8'hEE; bus.s0_sop = otherWren; bus.s0_eop = otherWren; bus.s0_wren = otherWren;
        end
        #1;
        rdyOwn   = (src == 0) ? bus.s0_rdy : bus.s1_rdy;
        rdyOther = (src == 0) ? bus.s1_rdy : bus.s0_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkTx(input string tag, input logic [7:0] data, input logic sop,
                           input logic eop, input logic err);
        checkOutput({tag, " tx_wren"}, bus.tx_wren, 1);
        checkOutput({tag, " tx_data"}, bus.tx_data, data);
        checkOutput({tag, " tx_sop"},  bus.tx_sop,  sop);
        checkOutput({tag, " tx_eop"},  bus.tx_eop,  eop);
        checkOutput({tag, " tx_err"},  bus.tx_err,  err);
    endtask

    // Count edges until the grant of 'src' rises (bounded) and compare.
    task automatic waitGrant(input int src, input int expLat, input string tag);
        int n;
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (gntOf(src)) begin
                n = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, n, expLat);
        checkOutput({tag, " other gnt"}, gntOf(1 - src), 0);
    endtask

    // Send a well-formed packet of 'len' bytes; optional intruder writes from
    // the other source on the first 'intrude' bytes, and an optional tx_a_full
    // stall of 'stallLen' cycles before byte 'stallAt'.
    task automatic runPacket(input int src, input int len, input int intrude,
                             input int stallAt, input int stallLen);
        logic r;
        logic o;
        for (int i = 0; i < len; i++) begin
            if (i == stallAt) begin
                bus.tx_a_full = 1'b1;
                for (int k = 0; k < stallLen; k++) begin
                    applyStimulus(src, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, r, o);
                    checkOutput("stall rdy", r, 0);
                    checkOutput("stall tx_wren", bus.tx_wren, 0);
                end
                bus.tx_a_full = 1'b0;
            end
            applyStimulus(src, byteVal(src, i), i == 0, i == len - 1, 1'b1, i < intrude, r, o);
            checkOutput("byte rdy", r, 1);
            if (i < intrude) checkOutput("intruder rdy", o, 0);
            checkTx("byte", byteVal(src, i), i == 0, i == len - 1, 1'b0);
        end
        idleInputs();
        checkOutput("gnt after eop", gntOf(src), 0);
    endtask

    initial begin
        logic r;
        logic o;
        int   pulsesBefore;
        int   errBefore;

        rst = 1'b1;
        bus.s0_req = 1'b0;
        bus.s1_req = 1'b0;
        bus.tx_rdy = 1'b1;
        bus.tx_a_full = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset s0_gnt", bus.s0_gnt, 0);
        checkOutput("reset s1_gnt", bus.s1_gnt, 0);
        checkOutput("reset s0_rdy", bus.s0_rdy, 0);
        checkOutput("reset tx_wren", bus.tx_wren, 0);
        checkOutput("reset tx_err", bus.tx_err, 0);
        checkOutput("reset abort_cnt", bus.abort_cnt, 0);
        rst = 1'b0;

        // Single 64-byte packet from source 0.
        bus.s0_req = 1'b1;
        waitGrant(0, 1, "t1 grant");
        bus.s0_req = 1'b0;
        pulsesBefore = wrenPulses;
        errBefore = errPulses;
        runPacket(0, 64, 0, -1, 0);
        @(posedge clk);
        #1;
        checkOutput("t1 idle tx_wren", bus.tx_wren, 0);
        checkOutput("t1 wren pulses", wrenPulses - pulsesBefore, 64);
        checkOutput("t1 err pulses", errPulses - errBefore, 0);

        // Both sources requesting continuously: 0,1,0,1 with a 4-cycle gap.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.s0_req = 1'b1;
        bus.s1_req = 1'b1;
        waitGrant(0, 1, "t2 grant0a");
        runPacket(0, 10, 0, -1, 0);
        waitGrant(1, 5, "t2 grant1a");
        runPacket(1, 10, 0, -1, 0);
        waitGrant(0, 5, "t2 grant0b");
        runPacket(0, 10, 0, -1, 0);
        waitGrant(1, 5, "t2 grant1b");
        runPacket(1, 10, 0, -1, 0);
        bus.s1_req = 1'b0;

        // Source 1 writes while source 0 owns the MAC.
        waitGrant(0, 5, "t3 grant");
        bus.s0_req = 1'b0;
        runPacket(0, 8, 5, -1, 0);

        // tx_a_full stall of 10 cycles mid-packet.
        bus.s0_req = 1'b1;
        waitGrant(0, 5, "t4 grant");
        bus.s0_req = 1'b0;
        runPacket(0, 20, 0, 6, 10);

        // 2000 bytes without eop: cut at byte 1514, pending s1 granted after gap.
        bus.s0_req = 1'b1;
        waitGrant(0, 5, "t5 grant");
        bus.s0_req = 1'b0;
        bus.s1_req = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(0, byteVal(0, i), i == 0, 1'b0, 1'b1, 1'b0, r, o);
            if (i < 1513) begin
                checkTx("long", byteVal(0, i), i == 0, 1'b0, 1'b0);
            end else if (i == 1513) begin
                checkTx("long cut", byteVal(0, i), 1'b0, 1'b1, 1'b1);
                checkOutput("long cut s0_gnt", bus.s0_gnt, 0);
            end else begin
                checkOutput("long dropped rdy", r, 0);
                checkOutput("long dropped tx_wren", bus.tx_wren, 0);
            end
            if (i == 1517) checkOutput("long s1_gnt early", bus.s1_gnt, 0);
            if (i == 1518) begin
                checkOutput("long s1_gnt", bus.s1_gnt, 1);
                bus.s1_req = 1'b0;
            end
        end
        idleInputs();
        checkOutput("long abort_cnt", bus.abort_cnt, 1);
        runPacket(1, 3, 0, -1, 0);

        // First byte without sop.
        bus.s0_req = 1'b1;
        waitGrant(0, 5, "nosop grant");
        bus.s0_req = 1'b0;
        applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, r, o);
        checkOutput("nosop rdy", r, 1);
        checkTx("nosop", 8'h5A, 1'b1, 1'b1, 1'b1);
        checkOutput("nosop abort_cnt", bus.abort_cnt, 2);
        checkOutput("nosop s0_gnt", bus.s0_gnt, 0);
        idleInputs();

        // Stray sop on the second byte.
        bus.s1_req = 1'b1;
        waitGrant(1, 5, "dupsop grant");
        bus.s1_req = 1'b0;
        applyStimulus(1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, r, o);
        checkTx("dupsop first", 8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, r, o);
        checkTx("dupsop second", 8'h22, 1'b0, 1'b1, 1'b1);
        checkOutput("dupsop abort_cnt", bus.abort_cnt, 3);
        checkOutput("dupsop s1_gnt", bus.s1_gnt, 0);
        idleInputs();

        // Legal one-byte packet.
        bus.s0_req = 1'b1;
        waitGrant(0, 5, "one grant");
        bus.s0_req = 1'b0;
        applyStimulus(0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, r, o);
        checkTx("one byte", 8'h77, 1'b1, 1'b1, 1'b0);
        checkOutput("one abort_cnt", bus.abort_cnt, 3);
        checkOutput("one s0_gnt", bus.s0_gnt, 0);
        idleInputs();

        // Reset in the middle of a packet, then a normal s1 packet.
        bus.s0_req = 1'b1;
        waitGrant(0, 5, "rst grant");
        bus.s0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, byteVal(0, i), i == 0, 1'b0, 1'b1, 1'b0, r, o);
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst s0_gnt", bus.s0_gnt, 0);
        checkOutput("rst s0_rdy", bus.s0_rdy, 0);
        checkOutput("rst tx_wren", bus.tx_wren, 0);
        checkOutput("rst tx_data", bus.tx_data, 0);
        checkOutput("rst abort_cnt", bus.abort_cnt, 0);
        idleInputs();
        @(posedge clk);
        #1;
        checkOutput("rst held tx_wren", bus.tx_wren, 0);
        rst = 1'b0;
        bus.s1_req = 1'b1;
        waitGrant(1, 1, "post rst grant");
        bus.s1_req = 1'b0;
        runPacket(1, 4, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
